// File: rtl/vjtag_word_rx_pkg.sv
// Purpose: shared sizing helpers and FSM state encoding for the virtual-JTAG word receiver.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
// Contents: clog2, ch_width (channel-index bits, never below 1), frame_width
// (channel bits + payload bits) and the receiver state enum.

package vjtag_pkg;

  // Ceiling log2, usable in constant expressions. clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // A single-channel build still carries one channel bit on the wire.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? clog2(num_ch) : 1;
  endfunction

  // Serial frame: channel index first, then payload, LSB first.
  function automatic int frame_width(input int num_ch, input int data_w);
    return ch_width(num_ch) + data_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } vjtag_state_e;

endpackage

// File: rtl/vjtag_word_rx_if.sv
// Purpose: bundles the virtual-JTAG pins and the deframed channel outputs of vjtag_word_rx.
// Latency: n/a (wires only).
// Backpressure: none; outputs are pulses/levels with no ready path.
// Signals: tck/tdi/v_sdr (jtag side, into receiver), tdo (loopback),
// oDATA/oVALID/oFLAG/oERR (channel side, out of receiver).
// master = the agent driving the jtag pins; slave = the receiver.

interface vjtag_word_rx_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4
);

  logic                     tck;
  logic                     tdi;
  logic                     v_sdr;
  logic                     tdo;
  logic [NUM_CH*DATA_W-1:0] oDATA;
  logic [NUM_CH-1:0]        oVALID;
  logic                     oFLAG;
  logic                     oERR;

  modport master (
    output tck, tdi, v_sdr,
    input  tdo, oDATA, oVALID, oFLAG, oERR
  );

  modport slave (
    input  tck, tdi, v_sdr,
    output tdo, oDATA, oVALID, oFLAG, oERR
  );

endinterface

// File: rtl/vjtag_word_rx_sync_edge.sv
// Purpose: STAGES-deep synchroniser for one asynchronous level, plus rising/falling edge pulses.
// Latency: sync follows din after STAGES clocks; rise/fall are combinational on sync vs. its delayed copy.
// Backpressure: none.
// Ports: iCLOCK_50, aclr (async, active high), din (raw input),
// sync (synchronised level), rise/fall (one-cycle edge pulses).

module vjtag_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic iCLOCK_50,
  input  logic aclr,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              sync_d;

  always_ff @(posedge iCLOCK_50 or posedge aclr) begin
    if (aclr) begin
      chain  <= '0;
      sync_d <= 1'b0;
    end else begin
      chain  <= {chain[STAGES-2:0], din};
      sync_d <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~sync_d;
  assign fall = ~sync & sync_d;

endmodule

// File: rtl/vjtag_word_rx.sv
// Purpose: oversamples virtual-JTAG tck/tdi/v_sdr on iCLOCK_50 and deframes {channel, data} shifts into channel registers.
// Latency: raw final tck rise -> oVALID/oDATA after SYNC_STAGES+2 clocks; oFLAG rises with oVALID.
// Backpressure: none; every completed frame is committed, the host paces tck.
// Ports: iCLOCK_50, aclr (async, active high), bus (slave side of vjtag_word_rx_if):
//   tck/tdi/v_sdr in, tdo = registered shreg[0], oDATA channel k at [k*DATA_W +: DATA_W],
//   oVALID one-cycle per-channel write strobe, oFLAG stretched frame flag, oERR abort/bad-channel pulse.

module vjtag_word_rx #(
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FLAG_HOLD   = 16
) (
  input  logic           iCLOCK_50,
  input  logic           aclr,
  vjtag_word_rx_if.slave bus
);

  import vjtag_pkg::*;

  localparam int CH_W    = ch_width(NUM_CH);
  localparam int FRAME_W = frame_width(NUM_CH, DATA_W);
  localparam int CNT_W   = clog2(FRAME_W);
  localparam int FLG_W   = clog2(FLAG_HOLD + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [FLG_W-1:0] FLG_LOAD = FLG_W'(FLAG_HOLD);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SHIFT  = SHIFT;
  localparam logic [1:0] ST_COMMIT = COMMIT;

  // ---------------------------------------------------------------
  // Input sampling. Only the tck rising edge and the tdi / v_sdr
  // levels are consumed; the remaining detector outputs are left idle.
  // ---------------------------------------------------------------
  logic tck_rise;
  logic tdi_s;
  logic vsdr_s;
  logic tck_lvl_unused;
  logic tck_fall_unused;
  logic tdi_rise_unused;
  logic tdi_fall_unused;
  logic vsdr_rise_unused;
  logic vsdr_fall_unused;

  vjtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_tck (
    .iCLOCK_50 (iCLOCK_50),
    .aclr      (aclr),
    .din       (bus.tck),
    .sync      (tck_lvl_unused),
    .rise      (tck_rise),
    .fall      (tck_fall_unused)
  );

  vjtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_tdi (
    .iCLOCK_50 (iCLOCK_50),
    .aclr      (aclr),
    .din       (bus.tdi),
    .sync      (tdi_s),
    .rise      (tdi_rise_unused),
    .fall      (tdi_fall_unused)
  );

  vjtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsdr (
    .iCLOCK_50 (iCLOCK_50),
    .aclr      (aclr),
    .din       (bus.v_sdr),
    .sync      (vsdr_s),
    .rise      (vsdr_rise_unused),
    .fall      (vsdr_fall_unused)
  );

  // ---------------------------------------------------------------
  // Deframing state
  // ---------------------------------------------------------------
  logic [1:0]               state;
  logic [FRAME_W-1:0]       shreg;
  logic [FRAME_W-1:0]       shreg_next;
  logic [CNT_W-1:0]         cnt;
  logic [CH_W-1:0]          frame_ch;
  logic [DATA_W-1:0]        frame_data;
  logic                     ch_ok;

  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [NUM_CH-1:0]        valid_q;
  logic                     err_q;
  logic [FLG_W-1:0]         flag_cnt;
  logic                     tdo_q;

  // LSB-first: new bits enter at the top, so after FRAME_W shifts the
  // first bit received sits in shreg[0] and the channel is the low field.
  assign shreg_next = {tdi_s, shreg[FRAME_W-1:1]};
  assign frame_ch   = shreg[CH_W-1:0];
  assign frame_data = shreg[FRAME_W-1:CH_W];
  assign ch_ok      = int'(frame_ch) < NUM_CH;

  always_ff @(posedge iCLOCK_50 or posedge aclr) begin
    if (aclr) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      data_q   <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
      flag_cnt <= '0;
      tdo_q    <= 1'b0;
    end else begin
      valid_q <= '0;
      err_q   <= 1'b0;
      tdo_q   <= shreg[0];

      // A commit below reloads the counter; that later assignment wins.
      if (flag_cnt != '0) begin
        flag_cnt <= flag_cnt - FLG_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (vsdr_s) begin
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // Leaving shift-DR takes priority over a coincident tck edge.
          if (!vsdr_s) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err_q <= (cnt != '0);
          end else if (tck_rise) begin
            shreg <= shreg_next;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_COMMIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        ST_COMMIT: begin
          if (ch_ok) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (int'(frame_ch) == k) begin
                data_q[k*DATA_W +: DATA_W] <= frame_data;
                valid_q[k]                 <= 1'b1;
              end
            end
            flag_cnt <= FLG_LOAD;
          end else begin
            err_q <= 1'b1;
          end

          // shreg is read above before this shift lands, so an edge here
          // becomes bit 0 of the next frame without disturbing the commit.
          if (vsdr_s) begin
            state <= ST_SHIFT;
            if (tck_rise) begin
              shreg <= shreg_next;
              cnt   <= CNT_W'(1);
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tdo    = tdo_q;
  assign bus.oDATA  = data_q;
  assign bus.oVALID = valid_q;
  assign bus.oERR   = err_q;
  assign bus.oFLAG  = (flag_cnt != '0);

endmodule
